// File: rtl/i2c_slave_regfile_pkg.sv
// Shared definitions for the I2C target register file: FSM states, default
// device address and register file depth.
package i2c_slave_regfile_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_ACK_DEV,
      ST_REG_ADDR,
      ST_ACK_REG,
      ST_WR_DATA,
      ST_ACK_WR,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   localparam logic [6:0] DEV_ADDR_DFLT = 7'b1000000;
   localparam int         REG_DEPTH     = 256;

endpackage

// File: rtl/i2c_slave_regfile_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from the synchronised levels.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Flops reset to 1 so a reset looks like an idle bus and creates no edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a 256 x 8 register file: pointer-byte writes, pointer-based
// reads with auto-increment, open-drain SDA drive via sda_oe.
module i2c_slave_regfile
   import i2c_slave_regfile_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DFLT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data
);

   logic       scl_rise, scl_fall, sda_s, start_det, stop_det;
   state_t     state, state_n;
   logic [3:0] bit_cnt, cnt_n;
   logic [7:0] shift, shift_n;
   logic [7:0] pointer, ptr_n;
   logic       rw, rw_n;
   logic       oe_n, busy_n, strobe_n, mem_we;
   logic [7:0] waddr_n, wdata_n;
   logic [7:0] byte_in, rd_byte;
   logic [7:0] regs [REG_DEPTH];

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign byte_in = {shift[6:0], sda_s};
   assign rd_byte = regs[pointer];

   always_comb begin
      state_n  = state;
      cnt_n    = bit_cnt;
      shift_n  = shift;
      ptr_n    = pointer;
      rw_n     = rw;
      oe_n     = sda_oe;
      busy_n   = busy;
      strobe_n = 1'b0;
      waddr_n  = wr_addr;
      wdata_n  = wr_data;
      mem_we   = 1'b0;
      if (start_det) begin
         state_n = ST_DEV_ADDR;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (stop_det) begin
         state_n = ST_IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         case (state)
            ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_n = byte_in;
                  cnt_n   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     cnt_n = 4'd0;
                     if (state == ST_DEV_ADDR) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                           state_n = ST_ACK_DEV;
                           busy_n  = 1'b1;
                           rw_n    = byte_in[0];
                        end else begin
                           state_n = ST_IGNORE;
                        end
                     end else if (state == ST_REG_ADDR) begin
                        ptr_n   = byte_in;
                        state_n = ST_ACK_REG;
                     end else begin
                        mem_we   = 1'b1;
                        strobe_n = 1'b1;
                        waddr_n  = pointer;
                        wdata_n  = byte_in;
                        ptr_n    = pointer + 8'd1;
                        state_n  = ST_ACK_WR;
                     end
                  end
               end
            end
            // First SCL fall starts the ACK pulse, the second one ends it.
            ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
               if (scl_fall) begin
                  if (!sda_oe) begin
                     oe_n = 1'b1;
                  end else begin
                     oe_n  = 1'b0;
                     cnt_n = 4'd0;
                     if (state == ST_ACK_DEV && rw) begin
                        state_n = ST_RD_DATA;
                        shift_n = rd_byte;
                        oe_n    = ~rd_byte[7];
                     end else if (state == ST_ACK_DEV) begin
                        state_n = ST_REG_ADDR;
                     end else begin
                        state_n = ST_WR_DATA;
                     end
                  end
               end
            end
            // shift[7] always holds the bit to present at the next SCL fall.
            ST_RD_DATA: begin
               if (scl_rise) begin
                  shift_n = {shift[6:0], 1'b0};
                  cnt_n   = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n    = 1'b0;
                     ptr_n   = pointer + 8'd1;
                     cnt_n   = 4'd0;
                     state_n = ST_RD_ACK;
                  end else begin
                     oe_n = ~shift[7];
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     shift_n = rd_byte;
                     cnt_n   = 4'd0;
                     state_n = ST_RD_DATA;
                  end else begin
                     state_n = ST_IGNORE;
                  end
               end
            end
            ST_IDLE, ST_IGNORE: oe_n = 1'b0;
            default: begin
               state_n = ST_IDLE;
               oe_n    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= 4'd0;
         shift     <= 8'd0;
         pointer   <= 8'd0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= 8'd0;
         wr_data   <= 8'd0;
         for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'd0;
      end else begin
         state     <= state_n;
         bit_cnt   <= cnt_n;
         shift     <= shift_n;
         pointer   <= ptr_n;
         rw        <= rw_n;
         sda_oe    <= oe_n;
         busy      <= busy_n;
         wr_strobe <= strobe_n;
         wr_addr   <= waddr_n;
         wr_data   <= wdata_n;
         if (mem_we) regs[pointer] <= wdata_n;
      end
   end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target device that sits directly downstream of the team's I2C master on the shared SCL/SDA bus.
- Answers to a 7-bit device address and exposes a 256 x 8 register file.
- Register writes use a pointer byte followed by data bytes. Register reads use the current pointer, normally set by a prior write of the pointer byte and a repeated START.
- Serves as the bench and FPGA counterpart for master write and read transactions.

Parameters:
- DEV_ADDR, 7'b1000000, device address the block ACKs.
- SYNC_STAGES, 2, synchroniser flops on scl and sda_in (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; one clock.
- scl  in  1  bus clock from the master; never driven by this block.
- sda_in  in  1  resolved SDA line level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from an address-matched START until the next STOP or START.
- wr_strobe  out  1  one-cycle pulse per register byte written.
- wr_addr  out  8  register index of the current wr_strobe.
- wr_data  out  8  byte written at the current wr_strobe.

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - state=IDLE; sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - Pointer=0; all 256 registers=0; synchroniser flops=1 (idle bus).
  - Reset mid-transfer: SDA released on the next clk. Block ignores the bus until a new START.
- Sampling:
  - scl and sda_in pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised values.
  - Bus requirement: SCL high and low phases each >= 4 clk.
- Conditions:
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - START and STOP are recognised in every state, including a repeated START.
  - START: state -> DEV_ADDR, bit counter cleared, sda_oe=0.
  - STOP: state -> IDLE, sda_oe=0, busy=0.
- Data rules:
  - Data bits are shifted MSB-first on the SCL rising edge.
  - sda_oe changes only on the clk after an SCL falling edge.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits {addr[6:0], rw}.
    - Match: ACK_DEV, busy=1, rw latched.
    - Mismatch: IGNORE, no ACK.
  - ACK_DEV: sda_oe=1 for the 9th SCL period. Then rw=0 -> REG_ADDR; rw=1 -> RD_DATA, with shift register loaded from regs[pointer].
  - REG_ADDR: shift 8 bits into pointer -> ACK_REG.
  - ACK_REG: ACK -> WR_DATA.
  - WR_DATA: 8 bits assembled. On the 8th SCL rise: regs[pointer] <= byte, wr_strobe pulses with wr_addr=pointer, then pointer+1 (mod 256). -> ACK_WR.
  - ACK_WR: ACK -> WR_DATA.
  - RD_DATA: bit driven as sda_oe = ~shift[7] after each SCL fall. After 8 bits, SDA released; pointer+1 (mod 256) -> RD_ACK.
  - RD_ACK: sample the master bit on SCL rise.
    - 0 (ACK): reload shift from regs[pointer] -> RD_DATA.
    - 1 (NACK): IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Boundaries:
  - Pointer wraps 0xFF -> 0x00 on both reads and writes.
  - STOP mid-byte discards the partial byte; no write occurs.
  - START and SCL edge in the same clk: START wins.
  - Write and pointer increment in the same clk use the old pointer for the write.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE);
  - DEV_ADDR default 7'b1000000;
  - REG_DEPTH=256.
- One sub-module, i2c_bus_sync: synchroniser plus edge and START/STOP detection. Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- Write 0xBA to reg 0x01 (addr 0x40, W) -> ACK on all three bytes; one wr_strobe with wr_addr=0x01, wr_data=0xBA; sda_oe=0 after STOP.
- Pointer write 0x01, repeated START, addr 0x40 R, master NACK -> slave drives 0xBA MSB-first; busy drops at STOP.
- Write 0x1D to reg 0x0A, then read reg 0x0A -> 0x1D. Reg 0x01 still reads 0xBA.
- Addr 0x41 W -> no ACK (sda_oe stays 0 in the 9th bit); no wr_strobe; the next START to 0x40 works.
- Pointer 0xFF, write 0x11, 0x22 -> wr_strobe at 0xFF then 0x00. A burst read from 0xFF with ACK returns 0x11, 0x22.
- rst=1 during the 5th data bit of a write -> sda_oe=0 on the next clk; target reg unchanged (0); the next transaction completes normally.
